usb_cmd_decoder: RTL and testbench

USB_CMD_DECODER -- requirements
Module: usb_cmd_decoder

---
 rtl/usb_cmd_decoder.sv | 183 ++++++++++++++++++
 tb/tb_usb_cmd_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: registered USB command words decoded into control
// registers, with read data returned through a fall-through response FIFO.
module usb_cmd_decoder #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int          CHANNEL    = 8,
  parameter int          RSP_DEPTH  = 16,
  parameter logic [31:0] VERSION    = 32'h0001_0000,
  parameter logic [31:0] PRODUCT    = 32'h0000_0325
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             usb_en,
  input  logic [DATA_WIDTH-1:0]            usb_data,
  input  logic [DATA_WIDTH*CHANNEL-1:0]    freq,
  input  logic [DATA_WIDTH-1:0]            temp,
  input  logic [3*DATA_WIDTH-1:0]          dna,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  input  logic                             rsp_ready,
  output logic                             capture,
  output logic                             rd_en_instr,
  output logic [DATA_WIDTH-1:0]            max_count,
  output logic [DATA_WIDTH-1:0]            max_time,
  output logic [CHANNEL-1:0]               channel_on,
  output logic [ADDR_WIDTH*CHANNEL-1:0]    ch_thresh,
  output logic [ADDR_WIDTH-1:0]            led
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic [3:0] {
    S_NONE, S_UPD, S_LED, S_CAP, S_RDI, S_MCL,
    S_MCH, S_MTL, S_MTH, S_RO, S_CON, S_CTH
  } sel_e;

  logic          usb_en_r;
  logic [DW-1:0] usb_data_r;
  logic [AW-1:0] mc_lo, mc_hi, mt_lo, mt_hi;
  logic [15:0]   err_cnt, drop_cnt;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [RSP_DEPTH];

  logic [AW-1:0] addr, pay;
  logic [14:0]   off;
  logic [7:0]    ch_idx;
  logic          is_rd, ch_ok;
  sel_e          sel;
  logic [DW-1:0] rd_word, push_word;
  logic          can_rd, can_wr, err, wr_go;
  logic          push, pop, full, do_push, drop;

  assign addr   = usb_data_r[DW-1:AW];
  assign pay    = usb_data_r[AW-1:0];
  assign is_rd  = addr[15];
  assign off    = addr[14:0];
  assign ch_idx = off[11:4];
  assign ch_ok  = (off[14:12] == 3'b001)
               && (int'(ch_idx) < CHANNEL);

  always_comb begin
    sel     = S_NONE;
    rd_word = '0;
    if (off[14:12] == 3'b001) begin
      if (ch_ok) begin
        case (off[3:0])
          4'h0:    sel = S_CON;
          4'h1:    sel = S_RO;
          4'h2:    sel = S_CTH;
          default: sel = S_NONE;
        endcase
        for (int i = 0; i < CHANNEL; i++) begin
          if (int'(ch_idx) == i) begin
            case (off[3:0])
              4'h0:    rd_word = DW'(channel_on[i]);
              4'h1:    rd_word = freq[i*DW +: DW];
              4'h2:    rd_word = DW'(ch_thresh[i*AW +: AW]);
              default: rd_word = '0;
            endcase
          end
        end
      end
    end else begin
      case (off)
        15'h000: sel = S_UPD;
        15'h001: begin sel = S_LED; rd_word = DW'(led);         end
        15'h002: sel = S_CAP;
        15'h003: begin sel = S_RDI; rd_word = DW'(rd_en_instr); end
        15'h004: begin sel = S_MCL; rd_word = DW'(mc_lo);       end
        15'h005: begin sel = S_MCH; rd_word = DW'(mc_hi);       end
        15'h006: begin sel = S_MTL; rd_word = DW'(mt_lo);       end
        15'h007: begin sel = S_MTH; rd_word = DW'(mt_hi);       end
        15'h010: begin sel = S_RO;  rd_word = DW'(VERSION);     end
        15'h011: begin sel = S_RO;  rd_word = DW'(PRODUCT);     end
        15'h012: begin sel = S_RO;  rd_word = temp;             end
        15'h013: begin sel = S_RO;  rd_word = dna[0*DW +: DW];  end
        15'h014: begin sel = S_RO;  rd_word = dna[1*DW +: DW];  end
        15'h015: begin sel = S_RO;  rd_word = dna[2*DW +: DW];  end
        15'h020: begin
          sel     = S_RO;
          rd_word = DW'({drop_cnt, err_cnt});
        end
        default: sel = S_NONE;
      endcase
    end
  end

  assign can_rd    = (sel != S_NONE) && (sel != S_UPD)
                  && (sel != S_CAP);
  assign can_wr    = (sel != S_NONE) && (sel != S_RO);
  assign err       = usb_en_r && (is_rd ? !can_rd : !can_wr);
  assign wr_go     = usb_en_r && !is_rd && can_wr;
  assign push      = usb_en_r && (is_rd || err);
  assign push_word = err ? '1 : rd_word;

  // A full FIFO still accepts a push when a pop frees a slot this edge.
  assign rsp_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]});
  assign pop       = rsp_valid && rsp_ready;
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign rsp_data  = rsp_valid ? mem[rd_ptr[PW-1:0]] : '0;

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_word;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      usb_en_r    <= 1'b0;
      usb_data_r  <= '0;
      mc_lo       <= '0;
      mc_hi       <= '0;
      mt_lo       <= '0;
      mt_hi       <= '0;
      err_cnt     <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      capture     <= 1'b0;
      rd_en_instr <= 1'b0;
      max_count   <= '0;
      max_time    <= '0;
      channel_on  <= '0;
      ch_thresh   <= '0;
      led         <= '0;
    end else begin
      usb_en_r <= usb_en;
      if (usb_en) usb_data_r <= usb_data;
      capture <= 1'b0;
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
      if (err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (wr_go) begin
        case (sel)
          S_UPD: if (pay[0]) begin
            max_count <= {mc_hi, mc_lo};
            max_time  <= {mt_hi, mt_lo};
          end
          S_LED: led         <= pay;
          S_CAP: capture     <= pay[0];
          S_RDI: rd_en_instr <= pay[0];
          S_MCL: mc_lo       <= pay;
          S_MCH: mc_hi       <= pay;
          S_MTL: mt_lo       <= pay;
          S_MTH: mt_hi       <= pay;
          S_CON:
            for (int i = 0; i < CHANNEL; i++)
              if (int'(ch_idx) == i) channel_on[i] <= pay[0];
          S_CTH:
            for (int i = 0; i < CHANNEL; i++)
              if (int'(ch_idx) == i) ch_thresh[i*AW +: AW] <= pay;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// tb_usb_cmd_decoder: directed and random commands checked against a
// behavioural register model through a response scoreboard.
module tb_usb_cmd_decoder;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int CH    = 8;
  localparam int DEPTH = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst, usb_en, rsp_ready;
  logic [DW-1:0]     usb_data, temp, rsp_data, max_count, max_time;
  logic [DW*CH-1:0]  freq;
  logic [3*DW-1:0]   dna;
  logic              rsp_valid, capture, rd_en_instr;
  logic [CH-1:0]     channel_on;
  logic [AW*CH-1:0]  ch_thresh;
  logic [AW-1:0]     led;

  usb_cmd_decoder dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .usb_en      (usb_en),
    .usb_data    (usb_data),
    .freq        (freq),
    .temp        (temp),
    .dna         (dna),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .capture     (capture),
    .rd_en_instr (rd_en_instr),
    .max_count   (max_count),
    .max_time    (max_time),
    .channel_on  (channel_on),
    .ch_thresh   (ch_thresh),
    .led         (led)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  logic [31:0] exp_q[$];

  logic [15:0] m_led, m_mcl, m_mch, m_mtl, m_mth;
  logic        m_rdi;
  logic [31:0] m_mc, m_mt;
  logic        m_on  [CH];
  logic [15:0] m_thr [CH];
  logic [31:0] m_freq[CH];
  logic [31:0] m_dna [3];
  int          m_err, m_drop;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_mcl = '0; m_mch = '0; m_mtl = '0; m_mth = '0;
    m_rdi = 1'b0; m_mc = '0; m_mt = '0; m_err = 0; m_drop = 0;
    for (int i = 0; i < CH; i++) begin
      m_on[i] = 1'b0;
      m_thr[i] = '0;
    end
  endtask

  task automatic model_cmd(input logic [15:0] addr, input logic [15:0] pay,
                           output bit push, output logic [31:0] w);
    bit rd;
    bit ok;
    int off, n, s;
    rd  = addr[15];
    off = int'(addr[14:0]);
    ok  = 1'b1;
    w   = '0;
    if ((off >> 12) == 1) begin
      n = (off >> 4) & 'hff;
      s = off & 'hf;
      if (n >= CH || s > 2) ok = 1'b0;
      else if (s == 0) begin
        if (rd) w = 32'(m_on[n]); else m_on[n] = pay[0];
      end else if (s == 1) begin
        if (rd) w = m_freq[n]; else ok = 1'b0;
      end else begin
        if (rd) w = 32'(m_thr[n]); else m_thr[n] = pay;
      end
    end else begin
      case (off)
        0: if (rd) ok = 1'b0;
           else if (pay[0]) begin
             m_mc = {m_mch, m_mcl};
             m_mt = {m_mth, m_mtl};
           end
        1: if (rd) w = 32'(m_led); else m_led = pay;
        2: ok = !rd;
        3: if (rd) w = 32'(m_rdi); else m_rdi = pay[0];
        4: if (rd) w = 32'(m_mcl); else m_mcl = pay;
        5: if (rd) w = 32'(m_mch); else m_mch = pay;
        6: if (rd) w = 32'(m_mtl); else m_mtl = pay;
        7: if (rd) w = 32'(m_mth); else m_mth = pay;
        'h10: if (rd) w = 32'h0001_0000; else ok = 1'b0;
        'h11: if (rd) w = 32'h0000_0325; else ok = 1'b0;
        'h12: if (rd) w = temp; else ok = 1'b0;
        'h13, 'h14, 'h15: if (rd) w = m_dna[off - 'h13]; else ok = 1'b0;
        'h20: if (rd) w = {m_drop[15:0], m_err[15:0]}; else ok = 1'b0;
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      if (m_err < 65535) m_err++;
      push = 1'b1;
      w = '1;
    end else begin
      push = rd;
    end
  endtask

  task automatic send(input logic [15:0] addr, input logic [15:0] pay,
                      input bit dropped = 1'b0);
    bit p;
    logic [31:0] w;
    int waited;
    waited = 0;
    model_cmd(addr, pay, p, w);
    if (p && !dropped && ready_mode != 0) begin
      while (exp_q.size() >= DEPTH && waited < 2000) begin
        @(posedge sys_clk); #1;
        waited++;
      end
      if (waited >= 2000) chk("fifo_room_timeout", 128'(waited), 0);
    end
    if (p && dropped) m_drop++;
    else if (p) exp_q.push_back(w);
    usb_en = 1'b1;
    usb_data = {addr, pay};
    @(posedge sys_clk); #1;
    usb_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    ready_mode = 2;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (t >= 500) chk("drain_timeout", 128'(exp_q.size()), 0);
    idle(2);
    chk("drained_empty", 128'(rsp_valid), 0);
  endtask

  task automatic check_regs();
    logic [CH-1:0]    on_v;
    logic [AW*CH-1:0] thr_v;
    for (int i = 0; i < CH; i++) begin
      on_v[i] = m_on[i];
      thr_v[i*AW +: AW] = m_thr[i];
    end
    chk("led", 128'(led), 128'(m_led));
    chk("rd_en_instr", 128'(rd_en_instr), 128'(m_rdi));
    chk("max_count", 128'(max_count), 128'(m_mc));
    chk("max_time", 128'(max_time), 128'(m_mt));
    chk("channel_on", 128'(channel_on), 128'(on_v));
    chk("ch_thresh", 128'(ch_thresh), 128'(thr_v));
    chk("capture_idle", 128'(capture), 0);
  endtask

  task automatic do_reset();
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 0);
    chk("rst_led", 128'(led), 0);
    chk("rst_channel_on", 128'(channel_on), 0);
    chk("rst_max_count", 128'(max_count), 0);
    exp_q.delete();
    model_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic count_capture(input string name, input int exp_n);
    int n;
    n = 0;
    repeat (6) begin
      @(posedge sys_clk); #1;
      if (capture) n++;
    end
    chk(name, 128'(n), 128'(exp_n));
  endtask

  always @(negedge sys_clk) begin
    logic [31:0] e;
    case (ready_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b1;
    endcase
    if (!sys_rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", 128'(rsp_data), 128'(e));
      end
    end
  end

  initial begin
    int offs[17] = '{'h0, 'h1, 'h2, 'h3, 'h4, 'h5, 'h6, 'h7, 'h10,
                     'h11, 'h12, 'h13, 'h14, 'h15, 'h20, 'h9, 'h7ff};
    logic [15:0] a;
    sys_rst = 1'b1;
    usb_en = 1'b0;
    usb_data = '0;
    rsp_ready = 1'b0;
    temp = $urandom;
    for (int i = 0; i < CH; i++) begin
      m_freq[i] = $urandom;
      freq[i*DW +: DW] = m_freq[i];
    end
    for (int i = 0; i < 3; i++) begin
      m_dna[i] = $urandom;
      dna[i*DW +: DW] = m_dna[i];
    end
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    chk("init_rsp_valid", 128'(rsp_valid), 0);
    chk("init_max_count", 128'(max_count), 0);
    chk("init_capture", 128'(capture), 0);
    chk("init_led", 128'(led), 0);

    // Version read latency and pop
    send(16'h8010, 16'h0);
    chk("lat_edge1", 128'(rsp_valid), 0);
    idle(1);
    chk("lat_edge2", 128'(rsp_valid), 1);
    chk("version", 128'(rsp_data), 128'(32'h0001_0000));
    drain();

    // Shadowed limits
    send(16'h0004, 16'h1234);
    send(16'h0005, 16'hABCD);
    idle(3);
    chk("mc_shadow", 128'(max_count), 0);
    send(16'h0000, 16'h0001);
    idle(3);
    chk("mc_commit", 128'(max_count), 128'(32'hABCD_1234));
    send(16'h0004, 16'h5555);
    send(16'h0000, 16'h0000);
    idle(3);
    chk("mc_no_update", 128'(max_count), 128'(32'hABCD_1234));
    send(16'h8005, 16'h0);
    send(16'h8000, 16'h0);
    drain();

    // Channel access and errors
    send(16'h1030, 16'h0001);
    idle(3);
    chk("ch3_on", 128'(channel_on), 128'(8'h08));
    send(16'h9031, 16'h0);
    send(16'h9080, 16'h0);
    send(16'h8020, 16'h0);
    drain();
    check_regs();

    // Capture pulse and reset with queued responses
    send(16'h0002, 16'h0001);
    count_capture("cap_pulse", 1);
    send(16'h0002, 16'h0000);
    count_capture("cap_none", 0);
    ready_mode = 0;
    send(16'h0001, 16'h00A5);
    repeat (3) send(16'h8011, 16'h0);
    idle(3);
    chk("queued_valid", 128'(rsp_valid), 1);
    chk("led_set", 128'(led), 128'(16'h00A5));
    do_reset();
    idle(3);
    chk("post_rst_empty", 128'(rsp_valid), 0);

    // Overflow
    ready_mode = 0;
    for (int i = 0; i < DEPTH + 3; i++)
      send(16'h8012, 16'h0, i >= DEPTH);
    send(16'h8020, 16'h0, 1'b1);
    idle(2);
    chk("fifo_full_valid", 128'(rsp_valid), 1);
    drain();
    ready_mode = 0;
    send(16'h8020, 16'h0);
    idle(2);
    chk("status_drop", 128'(rsp_data), 128'(32'h0004_0000));
    drain();

    // Random traffic
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4)
        a = {4'h1, 8'($urandom_range(0, 9)), 4'($urandom_range(0, 3))};
      else
        a = 16'(offs[$urandom_range(0, 16)]);
      a[15] = 1'($urandom_range(0, 1));
      send(a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (i % 100 == 99) begin
        idle(3);
        check_regs();
      end
    end
    send(16'h8020, 16'h0);
    drain();
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
